// File: rtl/reg_xfer_ctrl.sv
// Register-transfer command controller: result strobe 1 cycle after accept, flags (REG_XFER_FLAGS_EN) +1, then done.
// One command in flight; cmd_ready stays low from accept until the cycle after done.
module reg_xfer_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_imm,
   input  logic [15:0] rf_accumulator,
   input  logic [15:0] rf_x,
   input  logic [15:0] rf_y,
   input  logic [15:0] rf_sp,
   input  logic [7:0]  rf_p,
   output logic [15:0] rf_data,
   output logic        load_accumulator,
   output logic        load_x,
   output logic        load_y,
   output logic        load_sp,
   output logic        load_p,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
`ifdef REG_XFER_FLAGS_EN
      FLAGS = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] OP_TAX = 4'd1,  OP_TAY = 4'd2,  OP_TXA = 4'd3,  OP_TYA = 4'd4;
   localparam logic [3:0] OP_TSX = 4'd5,  OP_TXS = 4'd6,  OP_LDA = 4'd7,  OP_LDX = 4'd8;
   localparam logic [3:0] OP_LDY = 4'd9,  OP_INX = 4'd10, OP_DEX = 4'd11, OP_INY = 4'd12;
   localparam logic [3:0] OP_DEY = 4'd13;

   // destination one-hot: [0] accumulator, [1] x, [2] y, [3] sp
   localparam logic [3:0] DST_A = 4'b0001, DST_X = 4'b0010, DST_Y = 4'b0100, DST_S = 4'b1000;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] imm_q, imm_d;
   logic [15:0] rf_data_q, rf_data_d;
   logic [3:0]  ld_q, ld_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic [15:0] result;
   logic [3:0]  dest;
   logic        unused_p;

`ifdef REG_XFER_FLAGS_EN
   logic [15:0] result_q, result_d;
   logic        load_p_q, load_p_d;
   assign unused_p = rf_p[7] ^ rf_p[1];
`else
   assign unused_p = ^rf_p;
`endif

   always_comb begin
      result = 16'h0000;
      dest   = 4'b0000;
      case (op_q)
         OP_TAX:  begin result = rf_accumulator;  dest = DST_X; end
         OP_TAY:  begin result = rf_accumulator;  dest = DST_Y; end
         OP_TXA:  begin result = rf_x;            dest = DST_A; end
         OP_TYA:  begin result = rf_y;            dest = DST_A; end
         OP_TSX:  begin result = rf_sp;           dest = DST_X; end
         OP_TXS:  begin result = rf_x;            dest = DST_S; end
         OP_LDA:  begin result = imm_q;           dest = DST_A; end
         OP_LDX:  begin result = imm_q;           dest = DST_X; end
         OP_LDY:  begin result = imm_q;           dest = DST_Y; end
         OP_INX:  begin result = rf_x + 16'd1;    dest = DST_X; end
         OP_DEX:  begin result = rf_x - 16'd1;    dest = DST_X; end
         OP_INY:  begin result = rf_y + 16'd1;    dest = DST_Y; end
         OP_DEY:  begin result = rf_y - 16'd1;    dest = DST_Y; end
         default: begin result = 16'h0000;        dest = 4'b0000; end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      imm_d       = imm_q;
      rf_data_d   = rf_data_q;
      ld_d        = 4'b0000;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cmd_ready_d = cmd_ready_q;
`ifdef REG_XFER_FLAGS_EN
      result_d    = result_q;
      load_p_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // first IDLE cycle after done only re-raises cmd_ready
            if (!cmd_ready_q) begin
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end else if (cmd_valid) begin
               op_d        = cmd_op;
               imm_d       = cmd_imm;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = XFER;
            end
         end
         XFER: begin
            if (dest != 4'b0000) begin
               rf_data_d = result;
               ld_d      = dest;
            end
            state_d = DONE;
`ifdef REG_XFER_FLAGS_EN
            result_d = result;
            if (dest != 4'b0000 && op_q != OP_TXS) begin
               state_d = FLAGS;
            end
`endif
         end
`ifdef REG_XFER_FLAGS_EN
         FLAGS: begin
            rf_data_d = {8'h00, result_q[15], rf_p[6:2], (result_q == 16'h0000), rf_p[0]};
            load_p_d  = 1'b1;
            state_d   = DONE;
         end
`endif
         DONE: begin
            done_d  = 1'b1;
            err_d   = (op_q[3:1] == 3'b111);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= 4'd0;
         imm_q       <= 16'h0000;
         rf_data_q   <= 16'h0000;
         ld_q        <= 4'b0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
`ifdef REG_XFER_FLAGS_EN
         result_q    <= 16'h0000;
         load_p_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         imm_q       <= imm_d;
         rf_data_q   <= rf_data_d;
         ld_q        <= ld_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
`ifdef REG_XFER_FLAGS_EN
         result_q    <= result_d;
         load_p_q    <= load_p_d;
`endif
      end
   end

   assign cmd_ready        = cmd_ready_q;
   assign rf_data          = rf_data_q;
   assign load_accumulator = ld_q[0];
   assign load_x           = ld_q[1];
   assign load_y           = ld_q[2];
   assign load_sp          = ld_q[3];
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;
`ifdef REG_XFER_FLAGS_EN
   assign load_p           = load_p_q;
`else
   assign load_p           = 1'b0;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Scoreboard bench for reg_xfer_ctrl: expected writes, done pulses and cmd_ready rises are queued
// with their cycle stamps at issue time and matched by a negedge monitor.
module tb_reg_xfer_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [15:0] cmd_imm;
   logic [15:0] rf_accumulator, rf_x, rf_y, rf_sp;
   logic [7:0]  rf_p;
   logic [15:0] rf_data;
   logic        load_accumulator, load_x, load_y, load_sp, load_p;
   logic        busy, done, err;

   always #5 clk = ~clk;

   reg_xfer_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
      .rf_accumulator(rf_accumulator), .rf_x(rf_x), .rf_y(rf_y), .rf_sp(rf_sp), .rf_p(rf_p),
      .rf_data(rf_data),
      .load_accumulator(load_accumulator), .load_x(load_x), .load_y(load_y),
      .load_sp(load_sp), .load_p(load_p),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {int cyc; logic [4:0] ld; logic [15:0] dat;} wr_t;
   typedef struct {int cyc; logic err;} dn_t;

   wr_t wr_q[$];
   dn_t dn_q[$];
   int  rdy_q[$];
   wr_t we;
   dn_t de;
   int  re;

   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic mon_en = 1'b0;
   logic prev_rdy = 1'b1;
   logic [4:0] strb;

   assign strb = {load_p, load_sp, load_y, load_x, load_accumulator};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("onehot", 32'($countones(strb) <= 1), 32'd1);
         if (strb != 5'b0) begin
            chk("wr_pend", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
               we = wr_q.pop_front();
               chk("wr_cyc", 32'(cyc), 32'(we.cyc));
               chk("wr_ld", 32'(strb), 32'(we.ld));
               chk("wr_dat", 32'(rf_data), 32'(we.dat));
            end
         end
         if (done) begin
            chk("dn_pend", 32'(dn_q.size() > 0), 32'd1);
            if (dn_q.size() > 0) begin
               de = dn_q.pop_front();
               chk("dn_cyc", 32'(cyc), 32'(de.cyc));
               chk("dn_err", 32'(err), 32'(de.err));
            end
         end else begin
            chk("err_idle", 32'(err), 32'd0);
         end
         if (cmd_ready && !prev_rdy) begin
            chk("rdy_pend", 32'(rdy_q.size() > 0), 32'd1);
            if (rdy_q.size() > 0) begin
               re = rdy_q.pop_front();
               chk("rdy_cyc", 32'(cyc), 32'(re));
            end
         end
      end
      prev_rdy <= cmd_ready;
   end

   function automatic void model(input logic [3:0] op, input logic [15:0] imm,
                                 output logic [3:0] ld, output logic [15:0] r);
      ld = 4'b0000;
      r  = 16'h0000;
      case (op)
         4'd1:  begin ld = 4'b0010; r = rf_accumulator; end
         4'd2:  begin ld = 4'b0100; r = rf_accumulator; end
         4'd3:  begin ld = 4'b0001; r = rf_x; end
         4'd4:  begin ld = 4'b0001; r = rf_y; end
         4'd5:  begin ld = 4'b0010; r = rf_sp; end
         4'd6:  begin ld = 4'b1000; r = rf_x; end
         4'd7:  begin ld = 4'b0001; r = imm; end
         4'd8:  begin ld = 4'b0010; r = imm; end
         4'd9:  begin ld = 4'b0100; r = imm; end
         4'd10: begin ld = 4'b0010; r = rf_x + 16'd1; end
         4'd11: begin ld = 4'b0010; r = rf_x - 16'd1; end
         4'd12: begin ld = 4'b0100; r = rf_y + 16'd1; end
         4'd13: begin ld = 4'b0100; r = rf_y - 16'd1; end
         default: ;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [15:0] imm, input bit hold, input bit track);
      logic [3:0]  ld;
      logic [15:0] r;
      bit          fl;
      int          a;
      int          n;
      wr_t         w;
      dn_t         d;
      cmd_op    = op;
      cmd_imm   = imm;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("acc_wait", 32'(n < 40), 32'd1);
      a = cyc + 1;
      model(op, imm, ld, r);
`ifdef REG_XFER_FLAGS_EN
      fl = (ld != 4'b0000) && (op != 4'd6);
`else
      fl = 1'b0;
`endif
      if (track) begin
         if (ld != 4'b0000) begin
            w.cyc = a + 1; w.ld = {1'b0, ld}; w.dat = r;
            wr_q.push_back(w);
         end
         if (fl) begin
            w.cyc = a + 2; w.ld = 5'b10000;
            w.dat = {8'h00, r[15], rf_p[6:2], (r == 16'h0000), rf_p[0]};
            wr_q.push_back(w);
         end
         d.cyc = fl ? a + 3 : a + 2;
         d.err = (op >= 4'd14);
         dn_q.push_back(d);
         rdy_q.push_back(fl ? a + 4 : a + 3);
      end
      @(negedge clk);
      chk("acc_rdy", 32'(cmd_ready), 32'd0);
      chk("acc_busy", 32'(busy), 32'd1);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((wr_q.size() + dn_q.size() + rdy_q.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(n < 50), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   logic [3:0] ops [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd0, 4'd14, 4'd10};

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_imm = 16'h0;
      rf_accumulator = 16'h0; rf_x = 16'h0; rf_y = 16'h0; rf_sp = 16'h0; rf_p = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(cmd_ready), 32'd1);
      chk("rst_strb", 32'(strb), 32'd0);
      chk("rst_data", 32'(rf_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      rf_accumulator = 16'h8001; rf_x = 16'h1234; rf_y = 16'h5678; rf_sp = 16'h01F0; rf_p = 8'hA5;
      issue(4'd1, 16'h0, 1'b0, 1'b1);          // TAX, negative result
      wait_idle();
      rf_x = 16'hFFFF;
      issue(4'd10, 16'h0, 1'b0, 1'b1);         // INX wraps to zero
      wait_idle();
      rf_y = 16'h0000;
      issue(4'd13, 16'h0, 1'b0, 1'b1);         // DEY wraps to FFFF
      wait_idle();
      rf_x = 16'h01FF;
      issue(4'd6, 16'h0, 1'b0, 1'b1);          // TXS, no flags
      wait_idle();
      issue(4'd15, 16'h0, 1'b0, 1'b1);         // illegal
      wait_idle();
      rf_p = 8'h5A;
      issue(4'd7, 16'h0000, 1'b0, 1'b1);       // LDA# zero
      wait_idle();

      for (int i = 0; i < 12; i++) begin
         rf_accumulator = 16'($urandom);
         rf_x           = 16'($urandom);
         rf_y           = 16'($urandom);
         rf_sp          = 16'($urandom);
         rf_p           = 8'($urandom);
         issue(ops[i], 16'($urandom), 1'b0, 1'b1);
         wait_idle();
      end

      rf_accumulator = 16'h4321;
      issue(4'd7, 16'h1234, 1'b0, 1'b0);       // abort by reset during XFER
      reset = 1'b1;
      rdy_q.push_back(cyc + 1);
      @(negedge clk);
      chk("abort_strb", 32'(strb), 32'd0);
      chk("abort_rdy", 32'(cmd_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_data", 32'(rf_data), 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rdy2", 32'(cmd_ready), 32'd1);
      wait_idle();

      rf_accumulator = 16'h0F0F; rf_x = 16'h7FFF; rf_y = 16'h00FF; rf_sp = 16'h0100; rf_p = 8'hC3;
      issue(4'd8, 16'hBEEF, 1'b1, 1'b1);       // valid held across three commands
      issue(4'd12, 16'h0000, 1'b1, 1'b1);
      issue(4'd4, 16'h1111, 1'b0, 1'b1);
      wait_idle();
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port cmd_valid  input  1  command offered.
REQ-004 SHALL have port cmd_ready  output  1  controller idle and able to accept a command.
REQ-005 SHALL have port cmd_op  input  4  opcode: 0 NOP, 1 TAX, 2 TAY, 3 TXA, 4 TYA, 5 TSX, 6 TXS, 7 LDA#, 8 LDX#, 9 LDY#, 10 INX, 11 DEX, 12 INY, 13 DEY; 14-15 illegal.
REQ-006 SHALL have port cmd_imm  input  16  immediate operand for LDA#/LDX#/LDY#.
REQ-007 SHALL have ports rf_accumulator, rf_x, rf_y, rf_sp  input  16 each  current register-file contents.
REQ-008 SHALL have port rf_p  input  8  current status register.
REQ-009 SHALL have port rf_data  output  16  write data to register file.
REQ-010 SHALL have ports load_accumulator, load_x, load_y, load_sp, load_p  output  1 each  register-file write strobes.
REQ-011 SHALL have port busy  output  1  command in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  qualifies done; high for an illegal opcode.

Function
REQ-014 SHALL register all outputs; FSM states IDLE, XFER, FLAGS, DONE.
REQ-015 SHALL hold cmd_ready=1 only in IDLE; accept on a cycle with cmd_valid=1 and cmd_ready=1, latching cmd_op and cmd_imm.
REQ-016 SHALL go IDLE->XFER on accept; cmd_ready=0 and busy=1 from the following cycle until DONE has been exited.
REQ-017 SHALL in XFER compute result from rf_* sampled that cycle: TAX/TAY A, TXA/TXS X, TYA Y, TSX SP, LD# latched imm, INx/DEx source±1 modulo 2^16 (FFFF+1=0000, 0000-1=FFFF).
REQ-018 SHALL in the cycle after XFER drive rf_data=result with exactly one destination strobe high for one cycle (TAX/LDX#/INX/DEX/TSX->x; TAY/LDY#/INY/DEY->y; TXA/TYA/LDA#->accumulator; TXS->sp).
REQ-019 SHALL never assert more than one load_* strobe in any cycle.
REQ-020 SHALL for NOP and illegal opcodes assert no strobe and go XFER->DONE.
REQ-021 SHALL go XFER->FLAGS for all legal ops except NOP and TXS (when flags compiled in); TXS goes XFER->DONE.
REQ-022 SHALL in the cycle after FLAGS drive rf_data={8'h00, N, rf_p[6:2], Z, rf_p[0]} with load_p=1, where N=result[15] and Z=(result==0).
REQ-023 SHALL assert done=1 for exactly one cycle after DONE is entered, with err=1 only for opcodes 14-15; then return to IDLE.
REQ-024 Latency (flags in): accept at edge T; data strobe T+1; load_p T+2; done T+3; cmd_ready=1 at T+4.
REQ-025 SHALL ignore cmd_valid, cmd_op and cmd_imm changes while busy.

Reset
REQ-026 SHALL, when reset is sampled high, enter IDLE and clear rf_data, all load_*, busy, done and err to 0, and set cmd_ready to 1 after the edge.
REQ-027 SHALL abort any in-flight command on reset mid-operation, with no strobe, done or err after that edge.
REQ-028 SHALL not accept a command on a cycle where reset is high.

Configuration
REQ-029 SHALL compile the FLAGS state and the load_p write only when macro REG_XFER_FLAGS_EN is defined.
REQ-030 SHALL, without REG_XFER_FLAGS_EN, go XFER->DONE for every op, hold load_p=0, and give done at T+2 and cmd_ready at T+3.

Verification
REQ-031 After reset: cmd_ready=1, all strobes, rf_data, busy, done and err=0.
REQ-032 rf_accumulator=0x8001, TAX -> rf_data=0x8001 with load_x=1 at T+1; load_p=1 with rf_data bit7=1, bit1=0 at T+2; done at T+3.
REQ-033 rf_x=0xFFFF, INX -> rf_data=0x0000 with load_x=1; P write has Z=1, N=0. rf_y=0x0000, DEY -> rf_data=0xFFFF with load_y=1.
REQ-034 TXS with rf_x=0x01FF -> load_sp=1 with rf_data=0x01FF, no load_p, done at T+2; opcode 15 -> no strobes, done=1 with err=1.
REQ-035 LDA# imm=0x1234 with reset asserted at T+1 -> no strobes and no done after the reset edge; cmd_ready=1 afterwards.
REQ-036 Back-to-back cmd_valid held high for 3 commands -> each accepted only when cmd_ready=1; a one-hot strobe check holds every cycle.
